// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Brief    : Shared types and constants for the pc_sequencer program-flow block
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam int DEF_PC_W  = 10;
    localparam int DEF_LUT_W = 3;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Fixed branch destinations; the assembler emits lut_idx into instr[5:3].
    localparam logic [DEF_PC_W-1:0] TARGET_LUT [0:(1<<DEF_LUT_W)-1] = '{
        10'd0, 10'd4, 10'd16, 10'd32, 10'd64, 10'd128, 10'd256, 10'd512
    };

endpackage
`default_nettype wire

// File: rtl/branch_lut.sv
`default_nettype none
// ============================================================================
// Module   : branch_lut
// Brief    : Combinational index -> branch target read of the constant table
// Revision : 1.0 - initial release
// ============================================================================
module branch_lut
    import seq_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int LUT_W = DEF_LUT_W
) (
    input  logic [LUT_W-1:0] i_idx,
    output logic [PC_W-1:0]  o_target
);

    assign o_target = PC_W'(TARGET_LUT[i_idx]);

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program counter, start/done handshake, branch resolve, load stall
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int LUT_W = DEF_LUT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             halt,
    input  logic             branch,
    input  logic             br_cond,
    input  logic             mem_to_reg,
    input  logic [LUT_W-1:0] lut_idx,
    output logic [PC_W-1:0]  pc,
    output logic             run,
    output logic             stall,
    output logic             done,
    output logic [CNT_W-1:0] cycles
);

    seq_state_t       r_state;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_cycles;
    logic [PC_W-1:0]  w_target;
    logic [CNT_W-1:0] w_cycles_next;

    branch_lut #(
        .PC_W  (PC_W),
        .LUT_W (LUT_W)
    ) u_branch_lut (
        .i_idx    (lut_idx),
        .o_target (w_target)
    );

    assign w_cycles_next = (&r_cycles) ? r_cycles : r_cycles + CNT_W'(1);

    // Only req is looked at outside RUN, so X on other inputs cannot reach state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_pc     <= '0;
            r_cycles <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (req) begin
                        r_state  <= RUN;
                        r_pc     <= '0;
                        r_cycles <= '0;
                    end
                end
                RUN: begin
                    r_cycles <= w_cycles_next;
                    if (halt) begin
                        r_state <= DONE;
                    end else if (mem_to_reg) begin
                        r_state <= STALL;
                    end else if (branch && br_cond) begin
                        r_pc <= w_target;
                    end else begin
                        r_pc <= r_pc + PC_W'(1);
                    end
                end
                STALL: begin
                    r_cycles <= w_cycles_next;
                    r_pc     <= r_pc + PC_W'(1);
                    r_state  <= RUN;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Halt and the first cycle of a load must not commit a register/memory write.
    assign run    = ((r_state == RUN) && !halt && !mem_to_reg) || (r_state == STALL);
    assign stall  = (r_state == STALL);
    assign done   = (r_state == DONE);
    assign pc     = r_pc;
    assign cycles = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed + randomized bench for pc_sequencer against a flow model
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk;
    logic        rst_i, req_i, halt_i, br_i, cond_i, ld_i;
    logic [2:0]  idx_i;
    logic [9:0]  pc_o;
    logic        run_o, stall_o, done_o;
    logic [15:0] cycles_o;

    int total;
    int bad;

    // Reference model: phase 0 idle, 1 executing, 2 load wait, 3 finished
    int          m_ph;
    int unsigned m_pc;
    int unsigned m_cyc;
    int unsigned exp_lut [8] = '{0, 4, 16, 32, 64, 128, 256, 512};

    pc_sequencer dut (
        .clk        (clk),
        .reset      (rst_i),
        .req        (req_i),
        .halt       (halt_i),
        .branch     (br_i),
        .br_cond    (cond_i),
        .mem_to_reg (ld_i),
        .lut_idx    (idx_i),
        .pc         (pc_o),
        .run        (run_o),
        .stall      (stall_o),
        .done       (done_o),
        .cycles     (cycles_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Branch and load are exclusive by ISA encoding; the bench must never drive both.
    always @(posedge clk) begin
        assert (!(br_i === 1'b1 && ld_i === 1'b1))
            else $error("branch and mem_to_reg asserted together");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, q, h, b, c, l, input logic [2:0] ix);
        if (r) begin
            m_ph = 0; m_pc = 0; m_cyc = 0;
        end else begin
            case (m_ph)
                0, 3: if (q === 1'b1) begin m_ph = 1; m_pc = 0; m_cyc = 0; end
                1: begin
                    if (m_cyc < 65535) m_cyc++;
                    if (h)           m_ph = 3;
                    else if (l)      m_ph = 2;
                    else if (b && c) m_pc = exp_lut[ix];
                    else             m_pc = (m_pc + 1) % 1024;
                end
                default: begin
                    if (m_cyc < 65535) m_cyc++;
                    m_pc = (m_pc + 1) % 1024;
                    m_ph = 1;
                end
            endcase
        end
    endtask

    // Called just after a falling edge: drive, check, clock, advance model.
    task automatic cyc(input logic r, q, h, b, c, l, input logic [2:0] ix, input bit chk_en);
        bit exp_run;
        rst_i = r; req_i = q; halt_i = h; br_i = b; cond_i = c; ld_i = l; idx_i = ix;
        #1;
        if (chk_en) begin
            exp_run = (m_ph == 2) || (m_ph == 1 && h === 1'b0 && l === 1'b0);
            chk("pc",     32'(pc_o),     m_pc);
            chk("run",    32'(run_o),    32'(exp_run));
            chk("stall",  32'(stall_o),  32'(m_ph == 2));
            chk("done",   32'(done_o),   32'(m_ph == 3));
            chk("cycles", 32'(cycles_o), m_cyc);
        end
        @(posedge clk);
        model_step(r, q, h, b, c, l, ix);
        @(negedge clk);
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 3'd0, 1);
    endtask

    initial begin
        total = 0; bad = 0;
        m_ph = 0; m_pc = 0; m_cyc = 0;
        rst_i = 1; req_i = 0; halt_i = 0; br_i = 0; cond_i = 0; ld_i = 0; idx_i = 0;
        @(posedge clk);
        @(negedge clk);

        // Reset state; req under reset is ignored
        cyc(1, 1, 0, 0, 0, 0, 3'd0, 1);
        chk("rst_pc", 32'(pc_o), 0);
        chk("rst_done", 32'(done_o), 0);
        // X on don't-care inputs while idle
        cyc(0, 0, 1'bx, 1'b0, 1'bx, 1'b0, 3'bxxx, 1);
        chk("idle_pc_no_x", 32'(pc_o), 0);

        // Start and plain sequencing
        cyc(0, 1, 0, 0, 0, 0, 3'd0, 1);
        plain(3);
        chk("seq_pc3", 32'(pc_o), 3);
        chk("seq_cycles3", 32'(cycles_o), 3);
        plain(2);

        // Taken and not-taken branch at pc=5
        cyc(0, 0, 0, 1, 1, 0, 3'd3, 1);
        chk("br_taken", 32'(pc_o), 32);
        cyc(0, 0, 0, 1, 1, 0, 3'd1, 1);
        plain(1);
        cyc(0, 0, 0, 1, 0, 0, 3'd3, 1);
        chk("br_not_taken", 32'(pc_o), 6);
        plain(1);

        // Load at pc=7, then two back-to-back loads
        cyc(0, 0, 0, 0, 0, 1, 3'd0, 1);
        chk("ld_hold_pc", 32'(pc_o), 7);
        chk("ld_stall", 32'(stall_o), 1);
        plain(1);
        chk("ld_after", 32'(pc_o), 8);
        cyc(0, 0, 0, 0, 0, 1, 3'd0, 1);
        plain(1);
        cyc(0, 0, 0, 0, 0, 1, 3'd0, 1);
        plain(1);
        chk("ld_pair_pc", 32'(pc_o), 10);

        // Halt at pc=12, then restart
        plain(2);
        cyc(0, 0, 1, 0, 0, 0, 3'd0, 1);
        chk("halt_done", 32'(done_o), 1);
        chk("halt_pc", 32'(pc_o), 12);
        cyc(0, 0, 1'bx, 1'b0, 1'bx, 1'b0, 3'bxxx, 1);
        cyc(0, 1, 0, 0, 0, 0, 3'd0, 1);
        chk("restart_pc", 32'(pc_o), 0);
        chk("restart_done", 32'(done_o), 0);
        chk("restart_cycles", 32'(cycles_o), 0);

        // Reset while in STALL at pc=40
        cyc(0, 0, 0, 1, 1, 0, 3'd3, 1);
        plain(8);
        cyc(0, 0, 0, 0, 0, 1, 3'd0, 1);
        chk("stall_at40", 32'(pc_o), 40);
        cyc(1, 1, 0, 0, 0, 0, 3'd0, 1);
        chk("rst_stall_pc", 32'(pc_o), 0);
        chk("rst_stall_stall", 32'(stall_o), 0);
        chk("rst_stall_cycles", 32'(cycles_o), 0);
        plain(2);

        // PC wrap 0x3FF -> 0x000
        cyc(0, 1, 0, 0, 0, 0, 3'd0, 1);
        cyc(0, 0, 0, 1, 1, 0, 3'd7, 1);
        plain(511);
        chk("pc_max", 32'(pc_o), 32'h3FF);
        plain(1);
        chk("pc_wrap", 32'(pc_o), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, q, h, b, c, l;
            logic [2:0] ix;
            r  = ($urandom % 100) == 0;
            q  = ($urandom % 8) == 0;
            h  = ($urandom % 25) == 0;
            l  = ($urandom % 5) == 0;
            b  = !l && (($urandom % 4) == 0);
            c  = $urandom % 2;
            ix = 3'($urandom % 8);
            cyc(r, q, h, b, c, l, ix, 1);
        end

        // Cycle counter saturation
        cyc(1, 0, 0, 0, 0, 0, 3'd0, 1);
        cyc(0, 1, 0, 0, 0, 0, 3'd0, 1);
        for (int i = 0; i < 66000; i++) cyc(0, 0, 0, 0, 0, 0, 3'd0, (i % 4096) == 0);
        chk("cyc_sat", 32'(cycles_o), 32'hFFFF);
        plain(1);
        chk("cyc_sat_hold", 32'(cycles_o), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-flow controller for the 9-bit single-cycle core.
- Owns the program counter and the start/done handshake with the bench.
- Resolves taken branches through an internal target table.
- Inserts a one-cycle stall on loads to cover data-memory read latency.
- Produces the enable that qualifies the Control decoder's RegWrite/MemWrite, so no architectural write happens outside RUN.

Parameters:
PC_W, 10, program counter width (1024-entry instruction memory)
LUT_W, 3, branch-target table index width (2**LUT_W entries)
CNT_W, 16, cycle counter width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
req  input  1  start request from bench; sampled only in IDLE/DONE
halt  input  1  decoded halt instruction at current pc
branch  input  1  Control Branch output for current instruction
br_cond  input  1  ALU condition (1 = operands unequal, bne taken)
mem_to_reg  input  1  Control MemtoReg (load)
lut_idx  input  LUT_W  instr[5:3], branch-target table index
pc  output  PC_W  instruction-memory address
run  output  1  qualifies RegWrite/MemWrite; 1 only on commit cycles
stall  output  1  1 during the load wait cycle
done  output  1  program finished; held until next req
cycles  output  CNT_W  cycles spent in RUN+STALL, saturating

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset: state=IDLE, pc=0, run=0, stall=0, done=0, cycles=0.
- Reset dominates every other input on any cycle, including mid-program and during STALL.
- States: IDLE, RUN, STALL, DONE (enum in package).
- IDLE:
  - req=1 -> RUN next cycle, with pc=0 and cycles=0.
  - Otherwise hold.
- RUN: run=1; cycles increments, saturating at all-ones. Evaluate in priority order:
  1. halt=1 -> DONE. pc holds and no write is committed (run is forced 0 combinationally when halt=1).
  2. mem_to_reg=1 and not yet stalled -> STALL. pc holds; run=0 this cycle so the register write is deferred.
  3. branch=1 and br_cond=1 -> pc = target_lut[lut_idx].
  4. Otherwise pc = pc+1, wrapping modulo 2**PC_W (0x3FF -> 0x000, no error).
- STALL:
  - stall=1, run=1 (load data now valid, register write commits), cycles increments.
  - pc = pc+1 next cycle; back to RUN.
  - Exactly one stall per load; back-to-back loads each stall once.
- DONE:
  - done=1, run=0, pc and cycles hold.
  - req=1 -> RUN with pc=0, cycles=0, done deasserts the same edge.
- Latency: req to first commit = 1 cycle. Plain instruction = 1 cycle; load = 2 cycles; halt to done = 1 cycle.
- Branch and load are mutually exclusive by ISA encoding.
  - If both are asserted, load takes priority and the branch is ignored.
  - The verifier checks for this with an assertion.
- Target table:
  - Constant, 2**LUT_W entries of PC_W bits, defined in the package. Not writable at run time.
  - Default contents: entries 0..7 = 0, 4, 16, 32, 64, 128, 256, 512.
- req asserted in RUN/STALL is ignored; there is no restart mid-program.
- Inputs are don't-care outside RUN; X on inputs in IDLE/DONE must not propagate to state.

Decomposition:
- Package seq_pkg:
  - state enum seq_state_t {IDLE, RUN, STALL, DONE}
  - PC_W/LUT_W defaults
  - TARGET_LUT constant array
- One sub-module, branch_lut: a combinational index -> target read of TARGET_LUT, shared later with the assembler-check bench.
- Counter and FSM stay in pc_sequencer.

Test Plan:
- Reset then req pulse; inputs idle (no branch, no load, no halt) -> pc 0,1,2,3 on successive cycles, run=1, cycles=3 after 3 RUN cycles.
- At pc=5: branch=1, br_cond=1, lut_idx=3 -> pc=32 next cycle. Repeat with br_cond=0 -> pc=6.
- mem_to_reg=1 at pc=7:
  - Cycle 1: pc holds at 7, run=0.
  - Cycle 2: stall=1, run=1.
  - Then pc=8.
  - Two consecutive loads -> 4 cycles total, pc advances by 2.
- halt=1 at pc=12 -> next cycle done=1, pc stays 12, run=0. New req -> pc=0, done=0, cycles=0.
- Reset asserted during STALL at pc=40 -> next cycle state IDLE, pc=0, stall=0, cycles=0. req ignored while reset=1.
- Wrap and saturate:
  - Force pc to 0x3FF via branch into a table entry patched in the test package, then plain instruction -> pc=0x000.
  - Run 70000 cycles -> cycles saturates at 0xFFFF.
